mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous-read unified RAM between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the 5-stage pipeline CPU.
- Grants at most one requester per cycle. Data side has priority, with a starvation guard for fetch.
- Returns read data one cycle after grant, tagged to the granted side.
- Honours the writeback-stage cancel to drop stale fetch responses.

---
 rtl/arb_pkg.sv | 12 +
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/arb_starve_ctr.sv | 34 +++
 rtl/mem_port_arbiter.sv | 90 +++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_t;

  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and RAM-side signals of the unified memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned RAM_AW = 8
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              dm_req;
  logic [3:0]        dm_wen;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;

  logic              ram_en;
  logic [3:0]        ram_wen;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wen, dm_addr, dm_wdata, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           ram_en, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wen, dm_addr, dm_wdata, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           ram_en, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while fetch waits; asserts force_if at the limit.
module arb_starve_ctr
  import arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic if_req,
  input  logic if_gnt,
  input  logic dm_gnt,
  output logic force_if
);

  localparam logic [STARVE_CNT_W-1:0] MAX_CNT = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (if_gnt || !if_req)
      cnt_nxt = '0;
    else if (dm_gnt && (cnt != MAX_CNT))
      cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt <= '0;
    else         cnt <= cnt_nxt;
  end

  assign force_if = (cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-port unified RAM, data priority with fetch starvation guard.
// Optional grant/conflict statistics outputs when ARB_STATS_EN is defined.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned RAM_AW     = 8,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cancel,
  mem_port_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_if_cnt,
  output logic [31:0]       stat_dm_cnt,
  output logic [31:0]       stat_conflict_cnt
`endif
);

  logic   force_if;
  logic   if_gnt, dm_gnt;
  owner_t owner, owner_nxt;
  logic   wr_q, wr_nxt;

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk      (clk),
    .resetn   (resetn),
    .if_req   (bus.if_req),
    .if_gnt   (if_gnt),
    .dm_gnt   (dm_gnt),
    .force_if (force_if)
  );

  // Grants are additionally qualified by resetn so nothing reaches the RAM during reset.
  assign dm_gnt = resetn & bus.dm_req & ~force_if;
  assign if_gnt = resetn & bus.if_req & ~cancel & (~bus.dm_req | force_if);

  assign bus.dm_gnt    = dm_gnt;
  assign bus.if_gnt    = if_gnt;
  assign bus.ram_en    = dm_gnt | if_gnt;
  assign bus.ram_wen   = dm_gnt ? bus.dm_wen : '0;
  assign bus.ram_addr  = dm_gnt ? bus.dm_addr[RAM_AW+1:2] : bus.if_addr[RAM_AW+1:2];
  assign bus.ram_wdata = bus.dm_wdata;

  always_comb begin
    owner_nxt = OWN_NONE;
    wr_nxt    = 1'b0;
    if (dm_gnt) begin
      owner_nxt = OWN_DM;
      wr_nxt    = |bus.dm_wen;
    end else if (if_gnt) begin
      owner_nxt = OWN_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner <= OWN_NONE;
      wr_q  <= 1'b0;
    end else begin
      owner <= owner_nxt;
      wr_q  <= wr_nxt;
    end
  end

  assign bus.if_rvalid = resetn & (owner == OWN_IF) & ~cancel;
  assign bus.dm_rvalid = resetn & (owner == OWN_DM);
  assign bus.if_rdata  = bus.if_rvalid ? bus.ram_rdata : '0;
  assign bus.dm_rdata  = (bus.dm_rvalid && !wr_q) ? bus.ram_rdata : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:RAM_AW+2], bus.if_addr[1:0],
                              bus.dm_addr[31:RAM_AW+2], bus.dm_addr[1:0]};

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_if_cnt       <= '0;
      stat_dm_cnt       <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (if_gnt)                    stat_if_cnt       <= stat_if_cnt + 32'd1;
      if (dm_gnt)                    stat_dm_cnt       <= stat_dm_cnt + 32'd1;
      if (bus.if_req && bus.dm_req)  stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle reference model plus directed literal checks.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned SMAX = 3;
  localparam int unsigned NWORDS = 256;

  logic clk = 1'b0;
  logic resetn;
  logic cancel;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.RAM_AW(AW)) bus ();

`ifdef ARB_STATS_EN
  logic [31:0] stat_if_cnt, stat_dm_cnt, stat_conflict_cnt;
`endif

  mem_port_arbiter #(.RAM_AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk    (clk),
    .resetn (resetn),
    .cancel (cancel),
    .bus    (bus.slave)
`ifdef ARB_STATS_EN
    ,
    .stat_if_cnt       (stat_if_cnt),
    .stat_dm_cnt       (stat_dm_cnt),
    .stat_conflict_cnt (stat_conflict_cnt)
`endif
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 1) return 32'h2401_0001;
    if (i == 4) return 32'h1122_3344;
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // RAM seen by the DUT: synchronous read, byte-strobed write
  logic [31:0] ram [NWORDS];
  logic [31:0] ram_q;
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < NWORDS; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (bus.ram_en) begin
      ram_q <= ram[bus.ram_addr];
      for (int b = 0; b < 4; b++)
        if (bus.ram_wen[b]) ram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
    end
  end
  assign bus.ram_rdata = ram_q;

  int n_pass = 0;
  int n_total = 0;
  bit done = 1'b0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: arbitration rules, one pending response, shadow memory
  logic [31:0] m_mem [NWORDS];
  bit          m_init = 1'b0;
  int          m_starve = 0;
  int          m_pend = 0;          // 0 none, 1 fetch, 2 data
  logic [31:0] m_pend_data = '0;
  int          m_if_cnt = 0, m_dm_cnt = 0, m_cf_cnt = 0;

  always @(negedge clk) begin
    bit e_dm, e_if, e_irv, e_drv;
    int di, ii;
    if (!m_init) begin
      for (int i = 0; i < NWORDS; i++) m_mem[i] = init_word(i);
      m_init = 1'b1;
    end
    if (!done) begin
      di = int'((bus.dm_addr >> 2) % NWORDS);
      ii = int'((bus.if_addr >> 2) % NWORDS);
      e_dm = resetn && bus.dm_req && (m_starve != SMAX);
      e_if = resetn && bus.if_req && !cancel && (!bus.dm_req || m_starve == SMAX);
      e_irv = resetn && m_pend == 1 && !cancel;
      e_drv = resetn && m_pend == 2;

      chk("dm_gnt", 32'(bus.dm_gnt), 32'(e_dm));
      chk("if_gnt", 32'(bus.if_gnt), 32'(e_if));
      chk("ram_en", 32'(bus.ram_en), 32'(e_dm || e_if));
      chk("ram_wen", 32'(bus.ram_wen), e_dm ? 32'(bus.dm_wen) : 32'd0);
      if (e_dm) begin
        chk("ram_addr_dm", 32'(bus.ram_addr), 32'(di));
        chk("ram_wdata", bus.ram_wdata, bus.dm_wdata);
      end else if (e_if) begin
        chk("ram_addr_if", 32'(bus.ram_addr), 32'(ii));
      end
      chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_irv));
      chk("if_rdata", bus.if_rdata, e_irv ? m_pend_data : 32'd0);
      chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(e_drv));
      chk("dm_rdata", bus.dm_rdata, e_drv ? m_pend_data : 32'd0);
`ifdef ARB_STATS_EN
      chk("stat_if", stat_if_cnt, 32'(m_if_cnt));
      chk("stat_dm", stat_dm_cnt, 32'(m_dm_cnt));
      chk("stat_conflict", stat_conflict_cnt, 32'(m_cf_cnt));
`endif

      if (!resetn) begin
        m_starve = 0; m_pend = 0; m_pend_data = '0;
        m_if_cnt = 0; m_dm_cnt = 0; m_cf_cnt = 0;
      end else begin
        if (bus.if_req && bus.dm_req) m_cf_cnt++;
        if (e_dm) begin
          m_dm_cnt++;
          m_pend = 2;
          m_pend_data = (bus.dm_wen != 0) ? 32'd0 : m_mem[di];
          for (int b = 0; b < 4; b++)
            if (bus.dm_wen[b]) m_mem[di][8*b +: 8] = bus.dm_wdata[8*b +: 8];
        end else if (e_if) begin
          m_if_cnt++;
          m_pend = 1;
          m_pend_data = m_mem[ii];
        end else begin
          m_pend = 0;
        end
        if (e_if || !bus.if_req) m_starve = 0;
        else if (e_dm && m_starve < SMAX) m_starve++;
      end
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_wen = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
  endtask

  int order_c2 [5] = '{2, 2, 2, 1, 2};
  int order_c4 [4] = '{2, 2, 2, 1};

  initial begin
    resetn = 1'b0; cancel = 1'b0; idle();
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    @(negedge clk);
    chk("rst_dm_gnt", 32'(bus.dm_gnt), 32'd0);
    chk("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
    next(); idle(); resetn = 1'b1;
    @(negedge clk);
    chk("rst_rvalids", 32'({bus.if_rvalid, bus.dm_rvalid}), 32'd0);
    next();

    // fetch only, back-to-back
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    @(negedge clk); chk("t1_gnt0", 32'(bus.if_gnt), 32'd1);
    next(); bus.if_addr = 32'h4;
    @(negedge clk); chk("t1_gnt1", 32'(bus.if_gnt), 32'd1);
    next(); bus.if_addr = 32'hFFFF_F004;   // aliases to word 1
    @(negedge clk);
    chk("t1_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("t1_rdata", bus.if_rdata, 32'h2401_0001);
    next(); idle();
    @(negedge clk); chk("alias_rdata", bus.if_rdata, 32'h2401_0001);
    next();

    // contention: data priority, fetch forced after STARVE_MAX data grants
    bus.if_req = 1'b1; bus.if_addr = 32'h8; bus.dm_req = 1'b1; bus.dm_addr = 32'h20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("contention_order", bus.dm_gnt ? 32'd2 : (bus.if_gnt ? 32'd1 : 32'd0), 32'(order_c2[i]));
      next();
    end
    idle(); next();

    // partial write then read back
    bus.dm_req = 1'b1; bus.dm_wen = 4'b0011; bus.dm_addr = 32'h10; bus.dm_wdata = 32'hAABB_CCDD;
    @(negedge clk); chk("t3_wr_gnt", 32'(bus.dm_gnt), 32'd1);
    next(); bus.dm_wen = 4'b0000;
    @(negedge clk);
    chk("t3_wack", 32'(bus.dm_rvalid), 32'd1);
    chk("t3_wack_rdata", bus.dm_rdata, 32'd0);
    next(); idle();
    @(negedge clk); chk("t3_rd_rdata", bus.dm_rdata, 32'h1122_CCDD);
    next();

    // cancel drops the response and blocks the next fetch grant
    bus.if_req = 1'b1; bus.if_addr = 32'hC;
    @(negedge clk); chk("t4_gnt", 32'(bus.if_gnt), 32'd1);
    next(); cancel = 1'b1;
    @(negedge clk);
    chk("t4_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("t4_no_gnt", 32'(bus.if_gnt), 32'd0);
    next(); cancel = 1'b0;
    @(negedge clk); chk("t4_regnt", 32'(bus.if_gnt), 32'd1);
    next(); idle(); next();

    // reset mid-response, with starvation count part-way up
    bus.if_req = 1'b1; bus.if_addr = 32'h8; bus.dm_req = 1'b1; bus.dm_addr = 32'h4;
    repeat (2) begin
      @(negedge clk); chk("t5_pre_dm_gnt", 32'(bus.dm_gnt), 32'd1);
      next();
    end
    resetn = 1'b0;
    @(negedge clk);
    chk("t5_dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
    chk("t5_gnts", 32'({bus.if_gnt, bus.dm_gnt}), 32'd0);
    next(); resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) chk("t5_post_rvalid", 32'(bus.dm_rvalid), 32'd0);
      chk("t5_order", bus.dm_gnt ? 32'd2 : (bus.if_gnt ? 32'd1 : 32'd0), 32'(order_c4[i]));
      next();
    end
    idle(); next();

    // mixed traffic checked by the model
    for (int i = 0; i < 60; i++) begin
      bus.if_req   = ($urandom_range(0, 3) != 0);
      bus.if_addr  = $urandom;
      bus.dm_req   = ($urandom_range(0, 1) != 0);
      bus.dm_wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      bus.dm_addr  = {$urandom_range(0, 7), 2'b00} ^ 32'($urandom_range(0, 1) << 12);
      bus.dm_wdata = $urandom;
      cancel       = ($urandom_range(0, 4) == 0);
      next();
    end
    idle(); cancel = 1'b0; next();

`ifdef ARB_STATS_EN
    resetn = 1'b0; next(); resetn = 1'b1;
    bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.if_addr = 32'h0; bus.dm_addr = 32'h4;
    repeat (2) next();
    bus.dm_req = 1'b0;
    repeat (3) next();
    idle();
    @(negedge clk);
    chk("t6_stat_if", stat_if_cnt, 32'd3);
    chk("t6_stat_dm", stat_dm_cnt, 32'd2);
    chk("t6_stat_conflict", stat_conflict_cnt, 32'd2);
    next();
`endif

    @(negedge clk);
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
